// File: rtl/uart_alici.sv
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling with a divider latched per frame,
// and one-cycle result pulses (byte strobe, framing error, overrun).
module uart_alici (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_en_i,
    input  logic        rx_i,
    input  logic [15:0] baud_div_i,
    input  logic        fifo_dolu_i,
    output logic [7:0]  veri_o,
    output logic        veri_gecerli_o,
    output logic        cerceve_hatasi_o,
    output logic        tasma_hatasi_o,
    output logic        mesgul_o
);

    typedef enum logic [1:0] {StBosta, StBasla, StVeri, StDur} durum_e;

    durum_e      durum_q;
    logic        rx_meta_q;
    logic        rx_s_q;
    logic [15:0] sayac_q;
    logic [15:0] d_q;
    logic [15:0] h_q;
    logic [2:0]  bit_q;
    logic [7:0]  kaydirma_q;
    logic        sayac_h_son;
    logic        sayac_d_son;

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign sayac_h_son = (sayac_q == h_q - 16'd1);
    assign sayac_d_son = (sayac_q == d_q - 16'd1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q          <= StBosta;
            sayac_q          <= 16'd0;
            d_q              <= 16'd0;
            h_q              <= 16'd0;
            bit_q            <= 3'd0;
            kaydirma_q       <= 8'd0;
            veri_o           <= 8'd0;
            veri_gecerli_o   <= 1'b0;
            cerceve_hatasi_o <= 1'b0;
            tasma_hatasi_o   <= 1'b0;
            mesgul_o         <= 1'b0;
        end else begin
            veri_gecerli_o   <= 1'b0;
            cerceve_hatasi_o <= 1'b0;
            tasma_hatasi_o   <= 1'b0;
            case (durum_q)
                StBosta: begin
                    if (rx_en_i && !rx_s_q) begin
                        durum_q  <= StBasla;
                        sayac_q  <= 16'd0;
                        d_q      <= baud_div_i;
                        h_q      <= {1'b0, baud_div_i[15:1]};
                        mesgul_o <= 1'b1;
                    end
                end
                StBasla: begin
                    if (sayac_h_son) begin
                        sayac_q <= 16'd0;
                        if (!rx_s_q) begin
                            durum_q <= StVeri;
                            bit_q   <= 3'd0;
                        end else begin
                            durum_q  <= StBosta;
                            mesgul_o <= 1'b0;
                        end
                    end else begin
                        sayac_q <= sayac_q + 16'd1;
                    end
                end
                StVeri: begin
                    if (sayac_d_son) begin
                        // LSB arrives first, so shifting in at the MSB lines the byte up after 8.
                        kaydirma_q <= {rx_s_q, kaydirma_q[7:1]};
                        sayac_q    <= 16'd0;
                        if (bit_q == 3'd7) begin
                            durum_q <= StDur;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        sayac_q <= sayac_q + 16'd1;
                    end
                end
                StDur: begin
                    if (sayac_d_son) begin
                        durum_q  <= StBosta;
                        sayac_q  <= 16'd0;
                        mesgul_o <= 1'b0;
                        if (!rx_s_q) begin
                            cerceve_hatasi_o <= 1'b1;
                        end else if (fifo_dolu_i) begin
                            tasma_hatasi_o <= 1'b1;
                        end else begin
                            veri_o         <= kaydirma_q;
                            veri_gecerli_o <= 1'b1;
                        end
                    end else begin
                        sayac_q <= sayac_q + 16'd1;
                    end
                end
                default: begin
                    durum_q  <= StBosta;
                    mesgul_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alici.sv
// Self-checking bench for uart_alici: directed scenarios plus random 8N1 frames against an
// event-level model (expected pulse kind, cycle and byte per frame).
module tb_uart_alici;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        rx_en_i;
    logic        rx_i;
    logic [15:0] baud_div_i;
    logic        fifo_dolu_i;
    logic [7:0]  veri_o;
    logic        veri_gecerli_o;
    logic        cerceve_hatasi_o;
    logic        tasma_hatasi_o;
    logic        mesgul_o;

    localparam int KGood  = 0;
    localparam int KFrame = 1;
    localparam int KOver  = 2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Observed events are written only by the monitor; tests read from a base index.
    logic [47:0] ob_ev[$];
    logic [47:0] ex_ev[$];
    int          ob_base;
    int          busy_cnt = 0;
    int          busy_rise = -1;
    int          busy_last = -1;
    int          busy_base;
    logic        mesgul_prev = 1'b0;
    logic [7:0]  model_veri;

    uart_alici dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .rx_en_i          (rx_en_i),
        .rx_i             (rx_i),
        .baud_div_i       (baud_div_i),
        .fifo_dolu_i      (fifo_dolu_i),
        .veri_o           (veri_o),
        .veri_gecerli_o   (veri_gecerli_o),
        .cerceve_hatasi_o (cerceve_hatasi_o),
        .tasma_hatasi_o   (tasma_hatasi_o),
        .mesgul_o         (mesgul_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (veri_gecerli_o)   ob_ev.push_back({8'(KGood), 32'(cyc), veri_o});
        if (cerceve_hatasi_o) ob_ev.push_back({8'(KFrame), 32'(cyc), veri_o});
        if (tasma_hatasi_o)   ob_ev.push_back({8'(KOver), 32'(cyc), veri_o});
        if (mesgul_o) begin
            if (!mesgul_prev) busy_rise = cyc;
            busy_last = cyc;
            busy_cnt  = busy_cnt + 1;
        end
        mesgul_prev = mesgul_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) tick();
    endtask

    task automatic mark();
        ob_base   = ob_ev.size();
        busy_base = busy_cnt;
        ex_ev.delete();
    endtask

    // Line-level transmitter: start, 8 data bits LSB first, stop; each bit d cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int d,
                              input int div_late, output int e0);
        baud_div_i = 16'(d);
        rx_i = 1'b0;
        e0 = cyc + 1;
        repeat (d) tick();
        baud_div_i = 16'(div_late);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (d) tick();
        end
        rx_i = stop;
        repeat (d) tick();
        rx_i = 1'b1;
    endtask

    // One result per enabled frame, H + 9D + 2 cycles after the start edge.
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic full,
                               input int d, input int e0);
        int t;
        t = e0 + d / 2 + 9 * d + 2;
        if (!stop) begin
            ex_ev.push_back({8'(KFrame), 32'(t), model_veri});
        end else if (full) begin
            ex_ev.push_back({8'(KOver), 32'(t), model_veri});
        end else begin
            ex_ev.push_back({8'(KGood), 32'(t), b});
            model_veri = b;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        total++;
        if ({veri_o, veri_gecerli_o, cerceve_hatasi_o, tasma_hatasi_o, mesgul_o} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: got %h/%b%b%b%b want 00/0000", veri_o, veri_gecerli_o,
                     cerceve_hatasi_o, tasma_hatasi_o, mesgul_o);
        end
        rst_i = 1'b0;
        mark();
        idle(10);
        total++;
        if (busy_cnt != busy_base || ob_ev.size() != ob_base) begin
            bad++;
            $display("FAIL reset_idle: got busy=%0d events=%0d want 0/0", busy_cnt - busy_base,
                     ob_ev.size() - ob_base);
        end
    endtask

    task automatic test_good_frame();
        int e0;
        mark();
        send_frame(8'hA5, 1'b1, 8, 8, e0);
        model_frame(8'hA5, 1'b1, 1'b0, 8, e0);
        idle(20);
        total++;
        if (ob_ev.size() - ob_base != ex_ev.size()) begin
            bad++;
            $display("FAIL good_count: got %0d want %0d", ob_ev.size() - ob_base, ex_ev.size());
        end
        foreach (ex_ev[i]) begin
            total++;
            if (ob_base + i >= ob_ev.size() || ob_ev[ob_base + i] !== ex_ev[i]) begin
                bad++;
                $display("FAIL good_event %0d: got %h want %h", i,
                         (ob_base + i < ob_ev.size()) ? ob_ev[ob_base + i] : 48'h0, ex_ev[i]);
            end
        end
        total++;
        if (busy_rise != e0 + 2 || busy_last != e0 + 77 || busy_cnt - busy_base != 76) begin
            bad++;
            $display("FAIL good_busy: got rise=%0d last=%0d n=%0d want %0d/%0d/76", busy_rise,
                     busy_last, busy_cnt - busy_base, e0 + 2, e0 + 77);
        end
    endtask

    task automatic test_back_to_back();
        int e0a;
        int e0b;
        mark();
        send_frame(8'h00, 1'b1, 16, 16, e0a);
        send_frame(8'hFF, 1'b1, 16, 16, e0b);
        model_frame(8'h00, 1'b1, 1'b0, 16, e0a);
        model_frame(8'hFF, 1'b1, 1'b0, 16, e0b);
        idle(40);
        total++;
        if (ob_ev.size() - ob_base != ex_ev.size()) begin
            bad++;
            $display("FAIL b2b_count: got %0d want %0d", ob_ev.size() - ob_base, ex_ev.size());
        end
        foreach (ex_ev[i]) begin
            total++;
            if (ob_base + i >= ob_ev.size() || ob_ev[ob_base + i] !== ex_ev[i]) begin
                bad++;
                $display("FAIL b2b_event %0d: got %h want %h", i,
                         (ob_base + i < ob_ev.size()) ? ob_ev[ob_base + i] : 48'h0, ex_ev[i]);
            end
        end
    endtask

    task automatic test_glitch();
        int e0;
        mark();
        baud_div_i = 16'd8;
        rx_i = 1'b0;
        e0 = cyc + 1;
        repeat (2) tick();
        idle(15);
        total++;
        if (ob_ev.size() != ob_base) begin
            bad++;
            $display("FAIL glitch_events: got %0d want 0", ob_ev.size() - ob_base);
        end
        total++;
        if (busy_rise != e0 + 2 || busy_last != e0 + 5 || busy_cnt - busy_base != 4) begin
            bad++;
            $display("FAIL glitch_busy: got rise=%0d last=%0d n=%0d want %0d/%0d/4", busy_rise,
                     busy_last, busy_cnt - busy_base, e0 + 2, e0 + 5);
        end
    endtask

    task automatic test_framing();
        int e0;
        mark();
        send_frame(8'h96, 1'b0, 8, 8, e0);
        model_frame(8'h96, 1'b0, 1'b0, 8, e0);
        idle(30);
        total++;
        if (ob_ev.size() - ob_base != ex_ev.size()) begin
            bad++;
            $display("FAIL framing_count: got %0d want %0d", ob_ev.size() - ob_base, ex_ev.size());
        end
        foreach (ex_ev[i]) begin
            total++;
            if (ob_base + i >= ob_ev.size() || ob_ev[ob_base + i] !== ex_ev[i]) begin
                bad++;
                $display("FAIL framing_event %0d: got %h want %h", i,
                         (ob_base + i < ob_ev.size()) ? ob_ev[ob_base + i] : 48'h0, ex_ev[i]);
            end
        end
        total++;
        if (veri_o !== model_veri) begin
            bad++;
            $display("FAIL framing_keep: got %h want %h", veri_o, model_veri);
        end
    endtask

    task automatic test_overrun();
        int e0;
        mark();
        fifo_dolu_i = 1'b1;
        send_frame(8'h3C, 1'b1, 8, 8, e0);
        model_frame(8'h3C, 1'b1, 1'b1, 8, e0);
        idle(20);
        fifo_dolu_i = 1'b0;
        send_frame(8'h3C, 1'b1, 8, 8, e0);
        model_frame(8'h3C, 1'b1, 1'b0, 8, e0);
        idle(20);
        total++;
        if (ob_ev.size() - ob_base != ex_ev.size()) begin
            bad++;
            $display("FAIL overrun_count: got %0d want %0d", ob_ev.size() - ob_base, ex_ev.size());
        end
        foreach (ex_ev[i]) begin
            total++;
            if (ob_base + i >= ob_ev.size() || ob_ev[ob_base + i] !== ex_ev[i]) begin
                bad++;
                $display("FAIL overrun_event %0d: got %h want %h", i,
                         (ob_base + i < ob_ev.size()) ? ob_ev[ob_base + i] : 48'h0, ex_ev[i]);
            end
        end
    endtask

    task automatic test_enable();
        int e0;
        mark();
        rx_en_i = 1'b0;
        send_frame(8'h81, 1'b1, 8, 8, e0);
        idle(20);
        rx_en_i = 1'b1;
        total++;
        if (ob_ev.size() != ob_base || busy_cnt != busy_base) begin
            bad++;
            $display("FAIL enable_off: got events=%0d busy=%0d want 0/0", ob_ev.size() - ob_base,
                     busy_cnt - busy_base);
        end
        // Dropping the enable mid-frame must not abort it.
        mark();
        fork
            send_frame(8'hC3, 1'b1, 8, 8, e0);
            begin
                repeat (20) tick();
                rx_en_i = 1'b0;
            end
        join
        model_frame(8'hC3, 1'b1, 1'b0, 8, e0);
        idle(20);
        rx_en_i = 1'b1;
        total++;
        if (ob_ev.size() - ob_base != ex_ev.size()) begin
            bad++;
            $display("FAIL enable_mid_count: got %0d want %0d", ob_ev.size() - ob_base,
                     ex_ev.size());
        end
        foreach (ex_ev[i]) begin
            total++;
            if (ob_base + i >= ob_ev.size() || ob_ev[ob_base + i] !== ex_ev[i]) begin
                bad++;
                $display("FAIL enable_mid_event %0d: got %h want %h", i,
                         (ob_base + i < ob_ev.size()) ? ob_ev[ob_base + i] : 48'h0, ex_ev[i]);
            end
        end
    endtask

    task automatic test_div_change();
        int e0;
        mark();
        send_frame(8'h6E, 1'b1, 8, 12, e0);
        model_frame(8'h6E, 1'b1, 1'b0, 8, e0);
        idle(30);
        total++;
        if (ob_ev.size() - ob_base != ex_ev.size()) begin
            bad++;
            $display("FAIL divchg_count: got %0d want %0d", ob_ev.size() - ob_base, ex_ev.size());
        end
        foreach (ex_ev[i]) begin
            total++;
            if (ob_base + i >= ob_ev.size() || ob_ev[ob_base + i] !== ex_ev[i]) begin
                bad++;
                $display("FAIL divchg_event %0d: got %h want %h", i,
                         (ob_base + i < ob_ev.size()) ? ob_ev[ob_base + i] : 48'h0, ex_ev[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        mark();
        baud_div_i = 16'd8;
        rx_i = 1'b0;
        repeat (8) tick();
        rx_i = 1'b1;
        repeat (8) tick();
        rx_i = 1'b0;
        repeat (4) tick();
        total++;
        if (mesgul_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_busy_before: got %b want 1", mesgul_o);
        end
        rst_i = 1'b1;
        rx_i = 1'b1;
        tick();
        total++;
        if ({veri_o, veri_gecerli_o, cerceve_hatasi_o, tasma_hatasi_o, mesgul_o} !== 12'h000) begin
            bad++;
            $display("FAIL rstmid_outputs: got %h/%b%b%b%b want 00/0000", veri_o, veri_gecerli_o,
                     cerceve_hatasi_o, tasma_hatasi_o, mesgul_o);
        end
        rst_i = 1'b0;
        model_veri = 8'h00;
        idle(30);
        send_frame(8'h5A, 1'b1, 8, 8, e0);
        model_frame(8'h5A, 1'b1, 1'b0, 8, e0);
        idle(20);
        total++;
        if (ob_ev.size() - ob_base != ex_ev.size()) begin
            bad++;
            $display("FAIL rstmid_count: got %0d want %0d", ob_ev.size() - ob_base, ex_ev.size());
        end
        foreach (ex_ev[i]) begin
            total++;
            if (ob_base + i >= ob_ev.size() || ob_ev[ob_base + i] !== ex_ev[i]) begin
                bad++;
                $display("FAIL rstmid_event %0d: got %h want %h", i,
                         (ob_base + i < ob_ev.size()) ? ob_ev[ob_base + i] : 48'h0, ex_ev[i]);
            end
        end
    endtask

    task automatic test_random();
        int          e0;
        int          d;
        logic [7:0]  b;
        logic        stop;
        logic        full;
        logic        en;
        for (int n = 0; n < 20; n++) begin
            b    = 8'($urandom);
            d    = int'($urandom_range(4, 16));
            stop = ($urandom_range(0, 3) != 0);
            full = ($urandom_range(0, 3) == 0);
            en   = ($urandom_range(0, 4) != 0);
            mark();
            rx_en_i     = en;
            fifo_dolu_i = full;
            send_frame(b, stop, d, d, e0);
            if (en) model_frame(b, stop, full, d, e0);
            idle(2 * d + 10);
            rx_en_i     = 1'b1;
            fifo_dolu_i = 1'b0;
            total++;
            if (ob_ev.size() - ob_base != ex_ev.size()) begin
                bad++;
                $display("FAIL rand%0d_count: got %0d want %0d", n, ob_ev.size() - ob_base,
                         ex_ev.size());
            end
            foreach (ex_ev[i]) begin
                total++;
                if (ob_base + i >= ob_ev.size() || ob_ev[ob_base + i] !== ex_ev[i]) begin
                    bad++;
                    $display("FAIL rand%0d_event: got %h want %h (d=%0d)", n,
                             (ob_base + i < ob_ev.size()) ? ob_ev[ob_base + i] : 48'h0,
                             ex_ev[i], d);
                end
            end
            if (!en) begin
                total++;
                if (busy_cnt != busy_base) begin
                    bad++;
                    $display("FAIL rand%0d_disabled_busy: got %0d want 0", n,
                             busy_cnt - busy_base);
                end
            end
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        rx_i        = 1'b1;
        rx_en_i     = 1'b1;
        fifo_dolu_i = 1'b0;
        baud_div_i  = 16'd8;
        model_veri  = 8'h00;
        ob_base     = 0;
        busy_base   = 0;
        tick();
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overrun();
        test_enable();
        test_div_change();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
